// File: rtl/sha_result_merge.sv
// Rebuilds one AXI-Stream packet from the SHA wrapper's descriptor, payload and digest streams.
// Output order is descriptor beat, payload beats, then one digest beat that carries tlast.
`ifndef PANIC_DESC_WIDTH
`define PANIC_DESC_WIDTH 128
`endif

module sha_result_merge #(
    parameter int SWITCH_DATA_WIDTH = 512,
    parameter int SWITCH_KEEP_WIDTH = SWITCH_DATA_WIDTH / 8,
    parameter int DIGEST_BYTES      = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [`PANIC_DESC_WIDTH-1:0] s_desc_tdata,
    input  logic                         s_desc_tvalid,
    output logic                         s_desc_tready,
    input  logic [SWITCH_DATA_WIDTH-1:0] s_data_tdata,
    input  logic [SWITCH_KEEP_WIDTH-1:0] s_data_tkeep,
    input  logic                         s_data_tlast,
    input  logic                         s_data_tvalid,
    output logic                         s_data_tready,
    input  logic [511:0]                 s_sha_tdata,
    input  logic                         s_sha_tvalid,
    output logic                         s_sha_tready,
    output logic [SWITCH_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [SWITCH_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [31:0]                  pkt_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] DIGEST = 2'd2;

    function automatic logic [SWITCH_KEEP_WIDTH-1:0] low_ones(input int n);
        logic [SWITCH_KEEP_WIDTH-1:0] k;
        k = '0;
        for (int i = 0; i < SWITCH_KEEP_WIDTH; i++)
            if (i < n) k[i] = 1'b1;
        return k;
    endfunction

    localparam logic [SWITCH_KEEP_WIDTH-1:0] DIGEST_KEEP = low_ones(DIGEST_BYTES);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       load_en;
    logic       desc_hs;
    logic       data_hs;
    logic       sha_hs;

    // The output register can take a new beat when empty or when its beat leaves this cycle.
    assign load_en = !m_axis_tvalid || m_axis_tready;
    assign desc_hs = s_desc_tvalid && s_desc_tready;
    assign data_hs = s_data_tvalid && s_data_tready;
    assign sha_hs  = s_sha_tvalid && s_sha_tready;

    // NOTE: every output of this block gets a default first so no path leaves one unassigned
    // and infers a latch.
    always_comb begin
        state_nxt     = state;
        s_desc_tready = 1'b0;
        s_data_tready = 1'b0;
        s_sha_tready  = 1'b0;
        case (state)
            IDLE: begin
                s_desc_tready = load_en && !rst;
                if (s_desc_tvalid && s_desc_tready) state_nxt = DATA;
            end
            DATA: begin
                s_data_tready = load_en && !rst;
                if (s_data_tvalid && s_data_tready && s_data_tlast) state_nxt = DIGEST;
            end
            DIGEST: begin
                s_sha_tready = load_en && !rst;
                if (s_sha_tvalid && s_sha_tready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: the whole output beat is reset, not just tvalid, so a dropped beat leaves no stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            pkt_count     <= '0;
        end else begin
            if (desc_hs) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= SWITCH_DATA_WIDTH'(s_desc_tdata);
                m_axis_tkeep  <= '1;
                m_axis_tlast  <= 1'b0;
            end else if (data_hs) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_data_tdata;
                m_axis_tkeep  <= s_data_tkeep;
                m_axis_tlast  <= 1'b0;
            end else if (sha_hs) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= SWITCH_DATA_WIDTH'(s_sha_tdata);
                m_axis_tkeep  <= DIGEST_KEEP;
                m_axis_tlast  <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                pkt_count <= pkt_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_sha_result_merge.sv
// Randomised scoreboard bench for sha_result_merge: drivers feed the three input streams,
// a monitor compares every accepted output beat against the packet-level model.
`ifndef PANIC_DESC_WIDTH
`define PANIC_DESC_WIDTH 128
`endif

module tb_sha_result_merge;

    localparam int DW     = 512;
    localparam int KW     = 64;
    localparam int DESCW  = `PANIC_DESC_WIDTH;
    localparam int BUDGET = 2000;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [DESCW-1:0] s_desc_tdata;
    logic             s_desc_tvalid, s_desc_tready;
    logic [DW-1:0]    s_data_tdata;
    logic [KW-1:0]    s_data_tkeep;
    logic             s_data_tlast, s_data_tvalid, s_data_tready;
    logic [511:0]     s_sha_tdata;
    logic             s_sha_tvalid, s_sha_tready;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tlast, m_tvalid, m_tready;
    logic [31:0]      pkt_count;

    logic [DESCW-1:0] d32_desc_tdata;
    logic             d32_desc_tvalid, d32_desc_tready;
    logic [DW-1:0]    d32_data_tdata;
    logic [KW-1:0]    d32_data_tkeep;
    logic             d32_data_tlast, d32_data_tvalid, d32_data_tready;
    logic [511:0]     d32_sha_tdata;
    logic             d32_sha_tvalid, d32_sha_tready;
    logic [DW-1:0]    d32_m_tdata;
    logic [KW-1:0]    d32_m_tkeep;
    logic             d32_m_tlast, d32_m_tvalid;
    logic [31:0]      d32_pkt_count;

    always #5 clk = ~clk;

    sha_result_merge dut (
        .clk(clk), .rst(rst),
        .s_desc_tdata(s_desc_tdata), .s_desc_tvalid(s_desc_tvalid), .s_desc_tready(s_desc_tready),
        .s_data_tdata(s_data_tdata), .s_data_tkeep(s_data_tkeep), .s_data_tlast(s_data_tlast),
        .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
        .s_sha_tdata(s_sha_tdata), .s_sha_tvalid(s_sha_tvalid), .s_sha_tready(s_sha_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .pkt_count(pkt_count)
    );

    sha_result_merge #(.DIGEST_BYTES(32)) dut32 (
        .clk(clk), .rst(rst),
        .s_desc_tdata(d32_desc_tdata), .s_desc_tvalid(d32_desc_tvalid), .s_desc_tready(d32_desc_tready),
        .s_data_tdata(d32_data_tdata), .s_data_tkeep(d32_data_tkeep), .s_data_tlast(d32_data_tlast),
        .s_data_tvalid(d32_data_tvalid), .s_data_tready(d32_data_tready),
        .s_sha_tdata(d32_sha_tdata), .s_sha_tvalid(d32_sha_tvalid), .s_sha_tready(d32_sha_tready),
        .m_axis_tdata(d32_m_tdata), .m_axis_tkeep(d32_m_tkeep), .m_axis_tlast(d32_m_tlast),
        .m_axis_tvalid(d32_m_tvalid), .m_axis_tready(1'b1), .pkt_count(d32_pkt_count)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [576:0] act, input logic [576:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Packet-level model: queues of stimulus per stream plus the expected output order.
    logic [DESCW-1:0] q_desc[$];
    beat_t            q_pay[$];
    logic [511:0]     q_dig[$];
    beat_t            exp_q[$];
    int               exp_pkts = 0;
    int               rmode    = 0;

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [KW-1:0] low_keep(input int n);
        logic [KW-1:0] k;
        for (int i = 0; i < KW; i++) k[i] = (i < n);
        return k;
    endfunction

    task automatic add_packet(input logic [DESCW-1:0] desc, input int nbeats,
                              input bit rand_keep, input logic [511:0] dig);
        beat_t b;
        q_desc.push_back(desc);
        b.data = DW'(desc); b.keep = '1; b.last = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < nbeats; i++) begin
            b.data = rand512();
            if (!rand_keep)                   b.keep = '1;
            else if ($urandom_range(0, 5) == 0) b.keep = '0;
            else                              b.keep = {$urandom, $urandom};
            b.last = (i == nbeats - 1);
            q_pay.push_back(b);
            b.last = 1'b0;
            exp_q.push_back(b);
        end
        q_dig.push_back(dig);
        b.data = dig; b.keep = low_keep(64); b.last = 1'b1;
        exp_q.push_back(b);
    endtask

    task automatic drv_desc(input int maxidle, input int delay);
        int idle;
        bit ok;
        repeat (delay) begin @(posedge clk); #1; end
        while (q_desc.size() > 0) begin
            idle = $urandom_range(0, maxidle);
            repeat (idle) begin @(posedge clk); #1; end
            s_desc_tdata  = q_desc.pop_front();
            s_desc_tvalid = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < BUDGET; c++) begin
                @(negedge clk);
                if (s_desc_tready) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                check("desc_hs_timeout", ok, 1'b1);
                s_desc_tvalid = 1'b0; q_desc.delete(); return;
            end
            @(posedge clk); #1;
            s_desc_tvalid = 1'b0;
        end
    endtask

    task automatic drv_data(input int maxidle);
        int    idle;
        bit    ok;
        beat_t b;
        while (q_pay.size() > 0) begin
            idle = $urandom_range(0, maxidle);
            repeat (idle) begin @(posedge clk); #1; end
            b = q_pay.pop_front();
            s_data_tdata = b.data; s_data_tkeep = b.keep; s_data_tlast = b.last;
            s_data_tvalid = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < BUDGET; c++) begin
                @(negedge clk);
                if (s_data_tready) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                check("data_hs_timeout", ok, 1'b1);
                s_data_tvalid = 1'b0; q_pay.delete(); return;
            end
            @(posedge clk); #1;
            s_data_tvalid = 1'b0;
        end
    endtask

    task automatic drv_sha(input int maxidle);
        int idle;
        bit ok;
        while (q_dig.size() > 0) begin
            idle = $urandom_range(0, maxidle);
            repeat (idle) begin @(posedge clk); #1; end
            s_sha_tdata  = q_dig.pop_front();
            s_sha_tvalid = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < BUDGET; c++) begin
                @(negedge clk);
                if (s_sha_tready) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                check("sha_hs_timeout", ok, 1'b1);
                s_sha_tvalid = 1'b0; q_dig.delete(); return;
            end
            @(posedge clk); #1;
            s_sha_tvalid = 1'b0;
        end
    endtask

    task automatic run_phase(input int maxidle, input int desc_delay, input int sha_idle);
        bit ok;
        fork
            drv_desc(maxidle, desc_delay);
            drv_data(maxidle);
            drv_sha(sha_idle);
        join
        ok = 1'b0;
        for (int c = 0; c < 4 * BUDGET; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        check("drain", ok, 1'b1);
    endtask

    // Monitor: scoreboard compare, stall stability and stream-ordering rules.
    int    cyc = 0, first_cyc = -1, last_cyc = -1;
    int    desc_cnt = 0, data_last_cnt = 0, sha_cnt = 0;
    beat_t held, cur, e;
    bit    held_v = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            cur = {m_tdata, m_tkeep, m_tlast};
            if (held_v) begin
                check("stall_valid", m_tvalid, 1'b1);
                check("stall_data", cur, held);
            end
            held_v = 1'b0;
            if (m_tvalid && !m_tready) begin held = cur; held_v = 1'b1; end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got %0h with no beat expected", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", cur, e);
                    if (e.last) exp_pkts++;
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (s_desc_tready || s_data_tready || s_sha_tready)
                check("tready_onehot", $countones({s_desc_tready, s_data_tready, s_sha_tready}), 1);
            if (s_sha_tready)  check("sha_after_payload", data_last_cnt, sha_cnt + 1);
            if (s_desc_tready) check("desc_after_digest", desc_cnt, sha_cnt);
            if (s_data_tready) check("data_after_desc", desc_cnt, sha_cnt + 1);
            if (s_desc_tvalid && s_desc_tready) desc_cnt++;
            if (s_data_tvalid && s_data_tready && s_data_tlast) data_last_cnt++;
            if (s_sha_tvalid && s_sha_tready) sha_cnt++;
        end
    end

    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       m_tready = 1'b1;
                1:       m_tready = ~m_tready;
                default: m_tready = 1'b0;
            endcase
        end
    end

    task automatic apply_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        s_desc_tvalid = 1'b0; s_data_tvalid = 1'b0; s_sha_tvalid = 1'b0;
        #1;
        check("rst_tvalid", m_tvalid, 1'b0);
        check("rst_tdata", m_tdata, '0);
        check("rst_tkeep_tlast", {m_tkeep, m_tlast}, '0);
        check("rst_treadys", {s_desc_tready, s_data_tready, s_sha_tready}, 3'b000);
        check("rst_pkt_count", pkt_count, 32'd0);
        exp_q.delete(); exp_pkts = 0;
        desc_cnt = 0; data_last_cnt = 0; sha_cnt = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_d32();
        bit got, dh, ph, sh;
        d32_desc_tdata = DESCW'(32'h77); d32_desc_tvalid = 1'b1;
        d32_data_tdata = rand512(); d32_data_tkeep = '1; d32_data_tlast = 1'b1; d32_data_tvalid = 1'b1;
        d32_sha_tdata = rand512(); d32_sha_tvalid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (d32_m_tvalid && d32_m_tlast) begin
                check("digest_keep_32", d32_m_tkeep, low_keep(32));
                got = 1'b1;
            end
            dh = d32_desc_tready; ph = d32_data_tready; sh = d32_sha_tready;
            @(posedge clk); #1;
            if (dh) d32_desc_tvalid = 1'b0;
            if (ph) d32_data_tvalid = 1'b0;
            if (sh) d32_sha_tvalid = 1'b0;
        end
        check("digest_32_seen", got, 1'b1);
        d32_desc_tvalid = 1'b0; d32_data_tvalid = 1'b0; d32_sha_tvalid = 1'b0;
    endtask

    initial begin
        bit ok;
        int nb;
        rst = 1'b1;
        s_desc_tvalid = 1'b0; s_data_tvalid = 1'b0; s_sha_tvalid = 1'b0;
        s_desc_tdata = '0; s_data_tdata = '0; s_data_tkeep = '0; s_data_tlast = 1'b0; s_sha_tdata = '0;
        d32_desc_tvalid = 1'b0; d32_data_tvalid = 1'b0; d32_sha_tvalid = 1'b0;
        d32_desc_tdata = '0; d32_data_tdata = '0; d32_data_tkeep = '0; d32_data_tlast = 1'b0;
        d32_sha_tdata = '0;
        apply_reset();

        run_d32();

        // Single directed packet, then one whose digest is offered before its descriptor.
        add_packet(DESCW'(8'hA5), 2, 1'b0, 512'h1234);
        run_phase(0, 0, 0);
        check("pkt_count_single", pkt_count, 32'd1);
        add_packet(DESCW'(rand512()), 2, 1'b0, rand512());
        run_phase(1, 3, 0);
        check("pkt_count_early_digest", pkt_count, 32'd2);
        check("model_pkts_early_digest", pkt_count, 32'(exp_pkts));

        // 100 random packets under a toggling downstream ready.
        apply_reset();
        rmode = 1;
        for (int p = 0; p < 100; p++)
            add_packet(DESCW'(rand512()), int'($urandom_range(1, 4)), 1'b1, rand512());
        run_phase(3, 0, 3);
        check("pkt_count_100", pkt_count, 32'd100);

        // Back-to-back streaming: every cycle carries a beat.
        rmode = 0;
        repeat (2) begin @(posedge clk); #1; end
        nb = 0;
        for (int p = 0; p < 10; p++) begin
            add_packet(DESCW'(rand512()), 1 + (p % 3), 1'b0, rand512());
            nb += 3 + (p % 3);
        end
        first_cyc = -1;
        run_phase(0, 0, 0);
        check("b2b_span", last_cyc - first_cyc + 1, nb);
        check("pkt_count_110", pkt_count, 32'd110);

        // Reset asserted mid-DATA with a beat stalled in the output register.
        rmode = 2;
        repeat (2) begin @(posedge clk); #1; end
        s_desc_tdata = DESCW'(rand512()); s_desc_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_desc_tready) begin ok = 1'b1; break; end
        end
        check("mid_desc_hs", ok, 1'b1);
        @(posedge clk); #1;
        s_desc_tvalid = 1'b0;
        s_data_tdata = rand512(); s_data_tkeep = '1; s_data_tlast = 1'b0; s_data_tvalid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_tvalid_held", m_tvalid, 1'b1);
        check("mid_data_blocked", s_data_tready, 1'b0);
        apply_reset();
        rmode = 0;
        repeat (2) begin @(posedge clk); #1; end
        add_packet(DESCW'(rand512()), 3, 1'b1, rand512());
        run_phase(1, 0, 1);
        check("pkt_count_after_reset", pkt_count, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
